mix_bist_ctrl: RTL and testbench
================================

Name: mix_bist_ctrl

Overview:
- Built-in self-test driver for the small combinational mix netlists.
- Generates pseudo-random input vectors into the circuit under test (CUT) and compacts the CUT's output responses into a signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits on the stimulus/response side of the CUT: drives its primary inputs and reads back its primary outputs.

Parameters:
- PI_W, 7, CUT primary-input width (G1..G4, G5[2:0]); fixed at 7 by the LFSR polynomial.
- PO_W, 6, CUT primary-output width; must be ≤ MISR_W.
- NUM_PATTERNS, 64, vectors per run; legal range 1..127.
- LFSR_SEED, 7'h01, initial LFSR state; a value of 0 is replaced by 7'h01.
- MISR_W, 16, signature width; fixed at 16.
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; a run begins on a clock where start=1 and the FSM is in IDLE or DONE.
- cut_pi  out  PI_W  vector driven to the CUT inputs.
- cut_po  in  PO_W  CUT response; combinational from cut_pi, settles within one cycle.
- busy  out  1  high in APPLY, CAPTURE and COMPARE.
- done  out  1  high in DONE.
- pass  out  1  valid only while done=1; 1 when signature==GOLDEN.
- signature  out  MISR_W  current MISR contents.
- pattern_cnt  out  7  number of responses captured in the current run.

Behaviour:
- Reset values (asynchronous): state=IDLE, cut_pi=0, LFSR=LFSR_SEED (or 1 if the seed is 0), signature=0, pattern_cnt=0, busy=0, done=0, pass=0.
- FSM states: IDLE, APPLY, CAPTURE, COMPARE, DONE.
- IDLE: cut_pi=0. On start=1, go to APPLY, reload the LFSR with the seed, and clear signature and pattern_cnt.
- APPLY (1 cycle): cut_pi = current LFSR value. Go to CAPTURE.
- CAPTURE (1 cycle): cut_pi stays stable. At the exit edge, update all of the following together:
  - MISR: m' = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 0) ^ zero_extend(cut_po).
  - LFSR: L' = {L[5:0], L[6]^L[5]} (x^7+x^6+1, maximal, period 127).
  - pattern_cnt increments by 1.
  - If the incremented count == NUM_PATTERNS, go to COMPARE; otherwise go to APPLY.
- Cycle cost and latency:
  - Each pattern costs exactly 2 cycles.
  - start to done = 2*NUM_PATTERNS + 2 cycles (the COMPARE cycle plus the transition into DONE).
- COMPARE (1 cycle): registers pass = (signature == GOLDEN). Go to DONE.
- DONE:
  - done=1; pass, signature and pattern_cnt held; cut_pi=0.
  - start=1 begins a new run, with identical behaviour to IDLE+start, so the DONE→APPLY restart is seamless.
  - Otherwise stay in DONE. There is no automatic return to IDLE.
- start during APPLY, CAPTURE or COMPARE is ignored; runs are not restartable mid-flight.
- Reset asserted mid-run: immediate return to all reset values. No partial signature is retained; pass=0.
- pass is cleared to 0 when a new run starts and stays 0 until the next COMPARE.
- The LFSR never reaches 0. The first vector of every run is the seed.

Test Plan:
- Reset then idle: hold rst_n=0 → all outputs 0. Release with start=0 for 10 cycles → state stays IDLE, busy=0, cut_pi=0.
- Vector sequence: LFSR_SEED=1, start pulse. Sample cut_pi in each APPLY → 7'h01, 02, 04, 08, 10, 20, 41 for patterns 0..6.
- Zero response: cut_po tied to 0, NUM_PATTERNS=64, GOLDEN=0.
  - done asserts exactly 130 cycles after the start edge.
  - signature=16'h0000, pass=1, pattern_cnt=64.
- MISR arithmetic: cut_po tied to 6'h3F.
  - NUM_PATTERNS=1 → signature=16'h003F.
  - NUM_PATTERNS=2 → signature=16'h0041.
  - With GOLDEN=0 in both cases → pass=0.
- Mid-run reset: pull rst_n low at pattern 20 of 64 → outputs return to reset values immediately. A new start → a full 64-pattern run whose signature matches the uninterrupted run.
- Back-to-back runs and ignored start:
  - start held high through DONE → the second run restarts at seed 01 with signature cleared and pass dropping to 0 during the run.
  - start toggled during APPLY/CAPTURE → no effect on pattern_cnt progression.

Source files
------------

// File: rtl/mix_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mix_bist_ctrl
//   Built-in self-test driver for the small combinational mix netlists.
//   A 7-bit maximal LFSR (x^7 + x^6 + 1) supplies pseudo-random vectors to the
//   circuit under test; each response is folded into a 16-bit MISR
//   (CRC-CCITT polynomial 0x1021). After NUM_PATTERNS vectors the signature is
//   compared with GOLDEN and the verdict is held until the next run.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   level; begins a run when sampled in IDLE or DONE
//   cut_pi       out  [PI_W]   vector driven to the CUT primary inputs
//   cut_po       in   [PO_W]   CUT response, combinational from cut_pi
//   busy         out  high in APPLY, CAPTURE and COMPARE
//   done         out  high in DONE
//   pass         out  signature == GOLDEN, meaningful only while done = 1
//   signature    out  [MISR_W] current MISR contents
//   pattern_cnt  out  [7]      responses captured in the current run
// -----------------------------------------------------------------------------
module mix_bist_ctrl #(
    parameter int          PI_W         = 7,
    parameter int          PO_W         = 6,
    parameter int          NUM_PATTERNS = 64,
    parameter logic [6:0]  LFSR_SEED    = 7'h01,
    parameter int          MISR_W       = 16,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [PI_W-1:0]   cut_pi,
    input  logic [PO_W-1:0]   cut_po,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [6:0]        pattern_cnt
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [6:0]        SEED_EFF  = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
    localparam logic [6:0]        LAST_CNT  = 7'(NUM_PATTERNS);
    localparam logic [MISR_W-1:0] MISR_POLY = MISR_W'(16'h1021);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [6:0]         r_lfsr;
    logic [MISR_W-1:0]  r_misr;
    logic [6:0]         r_cnt;
    logic               r_pass;

    logic               w_run_start;
    logic               w_capture;
    logic               w_compare;
    logic [6:0]         w_cnt_inc;
    logic [MISR_W-1:0]  w_misr_nxt;
    logic [6:0]         w_lfsr_nxt;
    logic               w_drive_pi;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours, just like hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    assign w_cnt_inc = r_cnt + 7'd1;

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would make synthesis infer a latch to hold its old value.
    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        w_capture   = 1'b0;
        w_compare   = 1'b0;
        unique case (r_state)
            // DONE restarts exactly like IDLE so back-to-back runs are seamless.
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_run_start = 1'b1;
                end
            end
            S_APPLY: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = (w_cnt_inc == LAST_CNT) ? S_COMPARE : S_APPLY;
            end
            S_COMPARE: begin
                w_compare   = 1'b1;
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // LFSR / MISR / counter / verdict
    // -------------------------------------------------------------------------
    assign w_lfsr_nxt = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    assign w_misr_nxt = {r_misr[MISR_W-2:0], 1'b0}
                      ^ (r_misr[MISR_W-1] ? MISR_POLY : '0)
                      ^ MISR_W'(cut_po);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_EFF;
            r_misr <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else if (w_run_start) begin
            r_lfsr <= SEED_EFF;
            r_misr <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else if (w_capture) begin
            // The vector just captured stays on cut_pi throughout CAPTURE,
            // so the LFSR only advances once its response is absorbed.
            r_lfsr <= w_lfsr_nxt;
            r_misr <= w_misr_nxt;
            r_cnt  <= w_cnt_inc;
        end else if (w_compare) begin
            r_pass <= (r_misr == MISR_W'(GOLDEN));
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign w_drive_pi  = (r_state == S_APPLY) || (r_state == S_CAPTURE);
    assign cut_pi      = w_drive_pi ? PI_W'(r_lfsr) : '0;
    assign busy        = (r_state == S_APPLY) || (r_state == S_CAPTURE)
                      || (r_state == S_COMPARE);
    assign done        = (r_state == S_DONE);
    assign pass        = r_pass;
    assign signature   = r_misr;
    assign pattern_cnt = r_cnt;

endmodule

// File: tb/tb_mix_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mix_bist_ctrl
//   Directed bench for mix_bist_ctrl. The main instance runs 64 patterns
//   against a behavioural CUT whose response is selectable (all-zero or a
//   small mix function). Two extra instances with cut_po tied to 6'h3F check
//   the MISR arithmetic for one- and two-pattern runs.
//   Inputs are driven and outputs sampled on the falling edge. Cycle count c
//   is the number of falling edges since start was raised (c = 0), so the
//   first APPLY is seen at c = 1 and done at c = 2*64 + 2 = 130.
// -----------------------------------------------------------------------------
module tb_mix_bist_ctrl;

    localparam int NP = 64;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
        logic [6:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_small;
    int          po_mode;

    logic [6:0]  cut_pi;
    logic [5:0]  cut_po;
    logic        busy, done, pass;
    logic [15:0] signature;
    logic [6:0]  pattern_cnt;

    logic [6:0]  cut_pi_1, cut_pi_2;
    logic        busy_1, done_1, pass_1, busy_2, done_2, pass_2;
    logic [15:0] sig_1, sig_2;
    logic [6:0]  cnt_1, cnt_2;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];

    // Behavioural CUT: mode 0 -> all zero, mode 1 -> all ones, else a mix.
    function automatic logic [5:0] cut_model(input logic [6:0] pi, input int mode);
        if (mode == 0) return 6'h00;
        if (mode == 1) return 6'h3F;
        return {pi[6] ^ pi[0], pi[5] & pi[1], pi[4] | pi[2],
                pi[3] ^ pi[6], pi[2] ^ pi[1] ^ pi[0], ~pi[5]};
    endfunction

    assign cut_po = cut_model(cut_pi, po_mode);

    mix_bist_ctrl #(.NUM_PATTERNS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cut_pi(cut_pi), .cut_po(cut_po),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .pattern_cnt(pattern_cnt)
    );

    mix_bist_ctrl #(.NUM_PATTERNS(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(start_small), .cut_pi(cut_pi_1),
        .cut_po(6'h3F), .busy(busy_1), .done(done_1), .pass(pass_1),
        .signature(sig_1), .pattern_cnt(cnt_1)
    );

    mix_bist_ctrl #(.NUM_PATTERNS(2)) dut_n2 (
        .clk(clk), .rst_n(rst_n), .start(start_small), .cut_pi(cut_pi_2),
        .cut_po(6'h3F), .busy(busy_2), .done(done_2), .pass(pass_2),
        .signature(sig_2), .pattern_cnt(cnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy),        32'h0);
        check({tag, "_done"},  32'(done),        32'h0);
        check({tag, "_pass"},  32'(pass),        32'h0);
        check({tag, "_sig"},   32'(signature),   32'h0);
        check({tag, "_cnt"},   32'(pattern_cnt), 32'h0);
        check({tag, "_cutpi"}, 32'(cut_pi),      32'h0);
    endtask

    // One 64-pattern run on the main instance. Called on a falling edge with
    // the DUT in IDLE or DONE. toggle: random start activity while busy.
    // hold_end: leave start high from COMPARE on so the next run follows
    // immediately. abort_at: cycle at which reset is pulsed (0 = never).
    task automatic do_run(input int mode, input bit toggle, input bit hold_end,
                          input int abort_at);
        logic [6:0]  vec0 [7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
        logic [6:0]  vq[$];
        logic [6:0]  l;
        logic [6:0]  cur;
        logic [15:0] m;
        logic [5:0]  po;
        exp_t        e;

        l   = 7'h01;
        m   = 16'h0000;
        cur = 7'h00;
        for (int k = 0; k < NP; k++) begin
            vq.push_back((k < 7) ? vec0[k] : l);
            po = cut_model(l, mode);
            m  = (m << 1) ^ (m[15] ? 16'h1021 : 16'h0000) ^ {10'h000, po};
            l  = {l[5:0], l[6] ^ l[5]};
        end
        sb.push_back('{sig: m, pass: (m == 16'h0000), cnt: 7'(NP)});

        po_mode = mode;
        start   = 1'b1;
        for (int c = 1; c <= 2 * NP + 2; c++) begin
            @(negedge clk);
            if (c <= 2 * NP) start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            else             start = hold_end;

            if ((c % 2) == 1 && c < 2 * NP) begin
                cur = vq.pop_front();
                check("apply_cutpi", 32'(cut_pi),      32'(cur));
                check("apply_cnt",   32'(pattern_cnt), 32'((c - 1) / 2));
                check("apply_busy",  32'(busy),        32'h1);
                if (c == 1) begin
                    check("first_sig",  32'(signature), 32'h0);
                    check("first_pass", 32'(pass),      32'h0);
                    check("first_done", 32'(done),      32'h0);
                end
            end else if (c <= 2 * NP) begin
                check("capture_cutpi", 32'(cut_pi), 32'(cur));
            end else if (c == 2 * NP + 1) begin
                check("compare_busy", 32'(busy), 32'h1);
                check("compare_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                check("done_flag",  32'(done),        32'h1);
                check("done_busy",  32'(busy),        32'h0);
                check("done_cutpi", 32'(cut_pi),      32'h0);
                check("done_sig",   32'(signature),   32'(e.sig));
                check("done_pass",  32'(pass),        32'(e.pass));
                check("done_cnt",   32'(pattern_cnt), 32'(e.cnt));
            end

            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals("midrun_rst");
                void'(sb.pop_back());
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start_small = 1'b0;
        po_mode     = 0;

        // Reset held: every output at its reset value.
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy",  32'(busy),   32'h0);
            check("idle_cutpi", 32'(cut_pi), 32'h0);
            check("idle_done",  32'(done),   32'h0);
        end

        // MISR arithmetic with cut_po = 6'h3F for one and two patterns.
        start_small = 1'b1;
        @(negedge clk);
        start_small = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("n1_sig",  32'(sig_1),  32'h003F);
        check("n1_pass", 32'(pass_1), 32'h0);
        check("n1_cnt",  32'(cnt_1),  32'h1);
        check("n1_done", 32'(done_1), 32'h1);
        check("n2_sig",  32'(sig_2),  32'h0041);
        check("n2_pass", 32'(pass_2), 32'h0);
        check("n2_cnt",  32'(cnt_2),  32'h2);
        check("n2_done", 32'(done_2), 32'h1 & 32'(~busy_2));

        // Zero-response run (pass expected), start held so a second run with
        // the mix CUT follows immediately and random start toggling inside it.
        do_run(0, 1'b0, 1'b1, 0);
        do_run(2, 1'b1, 1'b0, 0);

        // DONE holds with start low.
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("hold_done", 32'(done),        32'h1);
        check("hold_cnt",  32'(pattern_cnt), 32'(NP));

        // Reset during pattern 20, then a full uninterrupted-equivalent run.
        do_run(2, 1'b0, 1'b0, 41);
        @(negedge clk);
        check_reset_vals("post_rst");
        do_run(2, 1'b0, 1'b0, 0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
